// File: rtl/inst_queue_pkg.sv
// Shared CPU types for the fetch/decode boundary.
// Holds the fetch-to-decode entry layout and the default queue depth.
package inst_queue_pkg;

    localparam int IQ_DEPTH = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
        logic        prediction;
        logic        branch;
        logic        jump;
    } pipe_in_t;

endpackage

// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: circular FIFO with flush.
// Occupancy is tracked by an explicit count, so full and empty never rely on pointer equality.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter  int DEPTH = IQ_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           enq_valid,
    input  pipe_in_t       enq_data,
    output logic           enq_ready,
    output logic           deq_valid,
    output pipe_in_t       deq_data,
    input  logic           deq_ready,
    input  logic           flush,
    output logic [PTR_W:0] count
);

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    pipe_in_t         r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;

    logic w_enq_fire;
    logic w_deq_fire;

    // Ready/valid come from the registered count only; no input-to-output paths.
    assign enq_ready  = (r_count != FULL_CNT);
    assign deq_valid  = (r_count != '0);
    assign deq_data   = deq_valid ? r_mem[r_head] : '0;
    assign count      = r_count;

    assign w_enq_fire = enq_valid & enq_ready;
    assign w_deq_fire = deq_valid & deq_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq_fire) r_tail <= r_tail + PTR_ONE;
            if (w_deq_fire) r_head <= r_head + PTR_ONE;
            case ({w_enq_fire, w_deq_fire})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is deliberately not reset; pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (w_enq_fire && !flush) r_mem[r_tail] <= enq_data;
    end

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: ordering, full/empty edges, wrap, flush and async reset.
module tb_inst_queue;
    import inst_queue_pkg::*;

    localparam int DEPTH = 8;
    localparam int PTR_W = $clog2(DEPTH);

    logic           clk;
    logic           reset;
    logic           enq_valid;
    pipe_in_t       enq_data;
    logic           enq_ready;
    logic           deq_valid;
    pipe_in_t       deq_data;
    logic           deq_ready;
    logic           flush;
    logic [PTR_W:0] count;

    int n_checks = 0;
    int n_err    = 0;

    inst_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .enq_valid (enq_valid),
        .enq_data  (enq_data),
        .enq_ready (enq_ready),
        .deq_valid (deq_valid),
        .deq_data  (deq_data),
        .deq_ready (deq_ready),
        .flush     (flush),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic pipe_in_t mk(input logic [31:0] pc);
        pipe_in_t e;
        e.pc          = pc;
        e.instruction = pc ^ 32'hA5A5_0000;
        e.prediction  = 1'b0;
        e.branch      = 1'b0;
        e.jump        = 1'b0;
        return e;
    endfunction

    initial begin
        pipe_in_t flg;
        reset     = 1'b0;
        enq_valid = 1'b0;
        enq_data  = '0;
        deq_ready = 1'b0;
        flush     = 1'b0;

        // Reset state
        #1;
        chk("rst_count", 128'(count), 128'(0));
        chk("rst_enq_ready", 128'(enq_ready), 128'(1));
        chk("rst_deq_valid", 128'(deq_valid), 128'(0));
        chk("rst_deq_data", 128'(deq_data), 128'(0));
        #2 reset = 1'b1;
        tick();

        // Three entries, no dequeue; head visible one cycle after first write
        enq_valid = 1'b1; enq_data = mk(32'h0);
        tick();
        chk("t1_first_visible", 128'(deq_data.pc), 128'(32'h0));
        chk("t1_count1", 128'(count), 128'(1));
        enq_data = mk(32'h4);
        tick();
        enq_data = mk(32'h8);
        tick();
        enq_valid = 1'b0;
        chk("t1_count3", 128'(count), 128'(3));
        deq_ready = 1'b1;
        chk("t1_pop0", 128'(deq_data.pc), 128'(32'h0));
        tick();
        chk("t1_pop1", 128'(deq_data.pc), 128'(32'h4));
        tick();
        chk("t1_pop2", 128'(deq_data.pc), 128'(32'h8));
        tick();
        deq_ready = 1'b0;
        chk("t1_empty_valid", 128'(deq_valid), 128'(0));
        chk("t1_empty_count", 128'(count), 128'(0));

        // Fill to full; 9th offer ignored; full-with-dequeue timing
        enq_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            enq_data = mk(32'h100 + 32'(4*i));
            tick();
        end
        chk("t2_full_count", 128'(count), 128'(8));
        chk("t2_full_ready", 128'(enq_ready), 128'(0));
        enq_data = mk(32'hDEAD);
        tick();
        chk("t2_ignored_count", 128'(count), 128'(8));
        deq_ready = 1'b1;
        chk("t2_ready_during_deq", 128'(enq_ready), 128'(0));
        tick();
        enq_valid = 1'b0;
        chk("t2_after_deq_count", 128'(count), 128'(7));
        chk("t2_after_deq_ready", 128'(enq_ready), 128'(1));
        for (int i = 1; i < 8; i++) begin
            chk("t2_drain", 128'(deq_data.pc), 128'(32'h100 + 32'(4*i)));
            tick();
        end
        deq_ready = 1'b0;
        chk("t2_drained", 128'(count), 128'(0));

        // Steady stream of 20 entries through an 8-deep queue
        enq_valid = 1'b1;
        deq_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            enq_data = mk(32'h200 + 32'(4*i));
            if (i > 0) begin
                chk("t3_count", 128'(count), 128'(1));
                chk("t3_data", 128'(deq_data), 128'(mk(32'h200 + 32'(4*(i-1)))));
            end
            tick();
        end
        enq_valid = 1'b0;
        chk("t3_last", 128'(deq_data.pc), 128'(32'h24C));
        tick();
        deq_ready = 1'b0;
        chk("t3_done", 128'(count), 128'(0));

        // Flush with simultaneous enqueue and dequeue
        enq_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            enq_data = mk(32'h300 + 32'(4*i));
            tick();
        end
        chk("t4_pre_count", 128'(count), 128'(5));
        flush = 1'b1; deq_ready = 1'b1; enq_data = mk(32'hBAD);
        tick();
        flush = 1'b0; deq_ready = 1'b0; enq_valid = 1'b0;
        chk("t4_count", 128'(count), 128'(0));
        chk("t4_deq_valid", 128'(deq_valid), 128'(0));
        chk("t4_deq_data", 128'(deq_data), 128'(0));
        chk("t4_enq_ready", 128'(enq_ready), 128'(1));
        enq_valid = 1'b1; enq_data = mk(32'h400);
        tick();
        enq_valid = 1'b0;
        chk("t4_post_count", 128'(count), 128'(1));
        chk("t4_post_pc", 128'(deq_data.pc), 128'(32'h400));
        deq_ready = 1'b1;
        tick();
        deq_ready = 1'b0;
        chk("t4_post_empty", 128'(deq_valid), 128'(0));

        // Predecode flags and instruction word pass through unchanged
        flg.pc = 32'h500; flg.instruction = 32'h00C5_8463;
        flg.prediction = 1'b1; flg.branch = 1'b1; flg.jump = 1'b0;
        enq_valid = 1'b1; enq_data = flg;
        tick();
        enq_valid = 1'b0;
        chk("t5_instr", 128'(deq_data.instruction), 128'(32'h00C5_8463));
        chk("t5_flags", 128'({deq_data.prediction, deq_data.branch, deq_data.jump}), 128'(3'b110));
        chk("t5_entry", 128'(deq_data), 128'(67'h0000_0500_00C5_8463 << 3 | 67'b110));
        deq_ready = 1'b1;
        tick();
        deq_ready = 1'b0;

        // Asynchronous reset mid-cycle with entries queued and handshakes active
        enq_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            enq_data = mk(32'h600 + 32'(4*i));
            tick();
        end
        chk("t6_pre_count", 128'(count), 128'(4));
        deq_ready = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("t6_async_count", 128'(count), 128'(0));
        chk("t6_async_valid", 128'(deq_valid), 128'(0));
        chk("t6_async_data", 128'(deq_data), 128'(0));
        #1 reset = 1'b1;
        deq_ready = 1'b0;
        enq_data = mk(32'h700);
        tick();
        enq_valid = 1'b0;
        chk("t6_post_count", 128'(count), 128'(1));
        chk("t6_post_pc", 128'(deq_data.pc), 128'(32'h700));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/inst_queue.md
# inst_queue

Instruction queue between the fetch stage and decode/issue. Buffers fetched entries (pc, instruction word, predecoded branch/jump flags, prediction bit) in a circular FIFO. Back-pressures fetch through its enable input when full. Drops all contents on a pipeline flush (misprediction or commit-time redirect).

## Interface
Parameters:
- DEPTH, 8, number of entries; power of two, at least 2
- PTR_W, $clog2(DEPTH), pointer width (derived; not overridden)

Ports:
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low; 0 clears the queue immediately
- enq_valid  in  1  fetch presents a valid entry this cycle
- enq_data  in  pipe_in_t  entry from fetch: pc[31:0], instruction[31:0], prediction, branch, jump
- enq_ready  out  1  queue can accept an entry; wired to fetch enable
- deq_valid  out  1  head entry is valid
- deq_data  out  pipe_in_t  head entry
- deq_ready  in  1  decode consumes the head this cycle
- flush  in  1  discard all entries (redirect from commit/branch resolution)
- count  out  PTR_W+1  number of occupied entries, 0..DEPTH

## Operation
- State: head and tail pointers (PTR_W bits, wrap modulo DEPTH); count register (PTR_W+1 bits); DEPTH-entry storage array.
- enq_fire = enq_valid & enq_ready. On enq_fire, write enq_data at tail and advance tail by 1.
- deq_fire = deq_valid & deq_ready. On deq_fire, advance head by 1.
- count next value: +1 on enq_fire only, -1 on deq_fire only, unchanged when both or neither fire.
- enq_ready = (count != DEPTH). Combinational from registered count only. No dependence on deq_ready, so there is no full-queue enqueue-while-dequeue pass-through.
- deq_valid = (count != 0). deq_data = storage[head] when deq_valid; all zeros when empty.
- No empty bypass: an entry written in cycle N is first visible on deq_* in cycle N+1.
- flush has priority over everything:
  - head, tail and count go to 0 at the next edge.
  - A same-cycle enq_fire or deq_fire has no effect on state. The dropped enqueue is lost by design; fetch is redirecting anyway.
- Storage contents are not cleared on reset or flush. Only pointers and count are.
- Pointer wrap: tail or head at DEPTH-1 advances to 0. Full versus empty is distinguished by count, never by pointer equality.

## Timing
- Reset values: enq_ready=1, deq_valid=0, deq_data=0, count=0. Reset takes effect asynchronously mid-cycle, regardless of in-flight handshakes.
- Enqueue-to-dequeue latency: 1 cycle minimum.
- Sustained throughput: 1 entry per cycle when fetch and decode both run every cycle and count is between 1 and DEPTH-1.
- Full with deq_fire: enq_ready stays 0 that cycle and becomes 1 in the next cycle.
- Empty with enq_fire: deq_valid rises in the next cycle.
- After flush: enq_ready=1 and deq_valid=0 in the following cycle; enqueue is legal in that cycle.
- All outputs are combinational from registered state. No combinational path from any input to any output.

## Structure
- pipe_in_t lives in the shared CPU types package. Add IQ_DEPTH (default 8) to the same package for top-level instantiation.
- No sub-module: storage, pointers and count are inline in inst_queue. Storage is a flop array indexed by head/tail.

## Test plan
- Reset, then enqueue pc=0x0,0x4,0x8 on consecutive cycles with deq_ready=0 -> count=3; deq_data.pc=0x0 from cycle 1 after the first write; FIFO order 0x0,0x4,0x8 when deq_ready is raised.
- Enqueue 8 entries with deq_ready=0 -> count=8, enq_ready=0; a 9th enq_valid is ignored. Raise deq_ready for one cycle -> enq_ready=1 on the next cycle and count=7.
- Steady stream of 20 entries with enq_valid=1 and deq_ready=1 -> every pointer wraps twice; output sequence equals input sequence; count stays at 1 after the first cycle.
- With 5 entries queued, assert flush together with enq_valid=1 and deq_ready=1 -> next cycle count=0, deq_valid=0, deq_data=0, enq_ready=1. The entry offered during flush never appears.
- Entry with branch=1, prediction=1, jump=0, instruction=0x00C58463 -> dequeued with all flag bits and the instruction word unchanged.
- Drive reset=0 asynchronously mid-cycle with 4 entries queued -> count=0 and deq_valid=0 before the next clk edge; operation is normal after reset=1.
